// File: rtl/fft_frame_tx_scheduler_pkg.sv
// Shared types and default sizing for the FFT frame transmit scheduler.
package fft_frame_tx_scheduler_pkg;

  localparam int DEF_N_POINTS    = 8;
  localparam int DEF_DW          = 8;
  localparam int DEF_GAP_CYCLES  = 100;
  localparam int DEF_TIMEOUT_CYC = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CALC    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_TX = 3'd3,
    ST_GAP     = 3'd4
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fft_frame_tx_scheduler_tx_gap_timer.sv
// Loadable down-counter with zero flag; shared by the CALC timeout and the inter-byte gap.
module fft_frame_tx_scheduler_tx_gap_timer #(
  parameter int W = 8
) (
  input  logic         i_Clk,
  input  logic         i_Rst_L,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/fft_frame_tx_scheduler.sv
// Triggers one FFT, snapshots its 2*N_POINTS result bytes and streams them re/im
// interleaved to a byte SPI master with a fixed idle gap after every byte.
module fft_frame_tx_scheduler
  import fft_frame_tx_scheduler_pkg::*;
#(
  parameter int N_POINTS    = DEF_N_POINTS,
  parameter int DW          = DEF_DW,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_sample,
  output logic                     o_fft_start,
  input  logic                     i_fft_ready,
  input  logic [2*N_POINTS*DW-1:0] i_fft_data,
  output logic [DW-1:0]            o_tx_byte,
  output logic                     o_tx_dv,
  input  logic                     i_tx_ready,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_timeout,
  output logic [7:0]               o_drop_cnt
);

  localparam int FRAME_BYTES = 2 * N_POINTS;
  localparam int IW          = $clog2(FRAME_BYTES);
  localparam int TW          = $clog2(max2(TIMEOUT_CYC, GAP_CYCLES) + 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   frame_q [FRAME_BYTES];
  logic [IW-1:0]   idx_q, idx_d;
  logic            seen_low_q, seen_low_d;
  logic            fft_start_q, fft_start_d;
  logic            timeout_q, timeout_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      drop_q, drop_d;
  logic            capture;
  logic            tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]   tmr_val;

  fft_frame_tx_scheduler_tx_gap_timer #(.W(TW)) u_timer (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .i_dec      (tmr_dec),
    .o_zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    seen_low_d   = seen_low_q;
    fft_start_d  = 1'b0;
    timeout_d    = 1'b0;
    frame_done_d = 1'b0;
    capture      = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = TW'(TIMEOUT_CYC - 1);
    tmr_dec      = 1'b0;
    o_tx_dv      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_sample) begin
          fft_start_d = 1'b1;
          tmr_load    = 1'b1;
          state_d     = ST_CALC;
        end
      end
      ST_CALC: begin
        // Ready is checked before the timer so a same-cycle ready beats the timeout.
        if (i_fft_ready) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = ST_SEND;
        end else if (tmr_zero) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SEND: begin
        if (i_tx_ready) begin
          o_tx_dv    = 1'b1;
          seen_low_d = 1'b0;
          state_d    = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (!i_tx_ready) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          seen_low_d = 1'b0;
          tmr_load   = 1'b1;
          tmr_val    = TW'(GAP_CYCLES);
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (idx_q == IW'(FRAME_BYTES - 1)) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy = (state_q != ST_IDLE);
  assign drop_d = (o_busy && i_sample && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      seen_low_q   <= 1'b0;
      fft_start_q  <= 1'b0;
      timeout_q    <= 1'b0;
      frame_done_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      seen_low_q   <= seen_low_d;
      fft_start_q  <= fft_start_d;
      timeout_q    <= timeout_d;
      frame_done_q <= frame_done_d;
      drop_q       <= drop_d;
    end
  end

  // Written only on capture, so the frame stays frozen until the next trigger.
  always_ff @(posedge i_Clk) begin
    for (int k = 0; k < FRAME_BYTES; k++) begin
      if (!i_Rst_L) begin
        frame_q[k] <= '0;
      end else if (capture) begin
        frame_q[k] <= i_fft_data[k*DW +: DW];
      end
    end
  end

  assign o_tx_byte    = frame_q[idx_q];
  assign o_fft_start  = fft_start_q;
  assign o_timeout    = timeout_q;
  assign o_frame_done = frame_done_q;
  assign o_drop_cnt   = drop_q;

endmodule

// File: tb/tb_fft_frame_tx_scheduler.sv
// Randomized frame-level bench for fft_frame_tx_scheduler with a responsive SPI model.
module tb_fft_frame_tx_scheduler;

  localparam int NP   = 8;
  localparam int DW   = 8;
  localparam int GAP  = 4;
  localparam int TOUT = 64;
  localparam int FB   = 2 * NP;

  logic           clk;
  logic           i_Rst_L;
  logic           i_sample;
  logic           o_fft_start;
  logic           i_fft_ready;
  logic [FB*DW-1:0] i_fft_data;
  logic [DW-1:0]  o_tx_byte;
  logic           o_tx_dv;
  logic           i_tx_ready;
  logic           o_busy;
  logic           o_frame_done;
  logic           o_timeout;
  logic [7:0]     o_drop_cnt;

  fft_frame_tx_scheduler #(
    .N_POINTS(NP), .DW(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYC(TOUT)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (i_Rst_L),
    .i_sample     (i_sample),
    .o_fft_start  (o_fft_start),
    .i_fft_ready  (i_fft_ready),
    .i_fft_data   (i_fft_data),
    .o_tx_byte    (o_tx_byte),
    .o_tx_dv      (o_tx_dv),
    .i_tx_ready   (i_tx_ready),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_timeout    (o_timeout),
    .o_drop_cnt   (o_drop_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int spi_lat = 16;
  bit spi_block = 1'b0;
  int drop_exp = 0;

  logic [7:0] tx_q[$];
  int txc_q[$], start_q[$], to_q[$], done_q[$], rise_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  // Event log sampled mid-cycle; the cycle number is the count of falling edges.
  initial begin
    logic prev_rdy;
    prev_rdy = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (o_tx_dv) begin
        tx_q.push_back(o_tx_byte);
        txc_q.push_back(cyc);
      end
      if (o_fft_start)  start_q.push_back(cyc);
      if (o_timeout)    to_q.push_back(cyc);
      if (o_frame_done) done_q.push_back(cyc);
      if (i_tx_ready && !prev_rdy) rise_q.push_back(cyc);
      prev_rdy = i_tx_ready;
    end
  end

  // SPI master model: ready drops after an accepted DV for spi_lat cycles.
  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (o_tx_dv) begin
        @(posedge clk);
        #1 i_tx_ready = 1'b0;
        repeat (spi_lat) @(posedge clk);
        #1 i_tx_ready = !spi_block;
      end else begin
        @(posedge clk);
        #1 i_tx_ready = !spi_block;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FB*DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic run_frame(input logic [FB*DW-1:0] data, input int rdly, input int lat,
                           input int novr, input bit ff_after, input bit bp);
    int b_tx, b_rise, b_start, b_done, s, off, budget;
    spi_lat = lat;
    off = bp ? 1 : 0;
    if (bp) begin
      spi_block = 1'b1;
      repeat (3) tick();
    end
    b_tx = tx_q.size(); b_rise = rise_q.size(); b_start = start_q.size(); b_done = done_q.size();
    i_sample = 1'b1; s = cyc + 1; tick(); i_sample = 1'b0;
    repeat (rdly) tick();
    i_fft_data = data; i_fft_ready = 1'b1; tick(); i_fft_ready = 1'b0;
    i_fft_data = ff_after ? '1 : rand_data();
    if (bp) begin
      repeat (50) tick();
      check("bp_no_dv", tx_q.size() - b_tx, 0);
      spi_block = 1'b0;
    end
    for (int i = 0; i < novr; i++) begin
      i_sample = 1'b1; tick(); i_sample = 1'b0; tick();
    end
    budget = 0;
    while (done_q.size() == b_done && budget < 4000) begin
      i_fft_data = ff_after ? '1 : rand_data();
      tick();
      budget++;
    end
    repeat (3) tick();
    drop_exp = (drop_exp + novr > 255) ? 255 : drop_exp + novr;
    check("frame_done_cnt", done_q.size() - b_done, 1);
    check("fft_start_cnt", start_q.size() - b_start, 1);
    if (start_q.size() > b_start) check("start_lat", start_q[b_start] - s, 1);
    check("dv_cnt", tx_q.size() - b_tx, FB);
    check("rise_cnt", rise_q.size() - b_rise, FB + off);
    check("drop_cnt", o_drop_cnt, drop_exp);
    check("busy_after", o_busy, 0);
    if (tx_q.size() - b_tx == FB && rise_q.size() - b_rise == FB + off
        && done_q.size() > b_done) begin
      for (int k = 0; k < FB; k++)
        check($sformatf("byte%0d", k), tx_q[b_tx + k], data[k*DW +: DW]);
      for (int k = 0; k < FB - 1; k++)
        check($sformatf("gap%0d", k), txc_q[b_tx + k + 1] - rise_q[b_rise + off + k], GAP + 2);
      check("done_gap", done_q[b_done] - rise_q[b_rise + off + FB - 1], GAP + 2);
      if (bp) check("bp_first_dv", txc_q[b_tx] - rise_q[b_rise], 0);
    end
  endtask

  initial begin
    logic [FB*DW-1:0] d;
    int b_tx, b_to, b_done, b_start, s, budget;
    i_Rst_L = 1'b0; i_sample = 1'b0; i_fft_ready = 1'b0; i_fft_data = '0;
    repeat (3) tick();
    check("rst_busy", o_busy, 0);
    check("rst_dv", o_tx_dv, 0);
    check("rst_start", o_fft_start, 0);
    check("rst_drop", o_drop_cnt, 0);
    check("rst_byte", o_tx_byte, 0);
    i_Rst_L = 1'b1;
    tick();

    // Normal frame with counting data bytes.
    for (int k = 0; k < FB; k++) d[k*DW +: DW] = 8'h10 + 8'(k);
    run_frame(d, 5, 16, 0, 1'b0, 1'b0);

    // Timeout: ready arrives one cycle too late and must be ignored.
    b_tx = tx_q.size(); b_to = to_q.size(); b_done = done_q.size(); b_start = start_q.size();
    i_sample = 1'b1; s = cyc + 1; tick(); i_sample = 1'b0;
    repeat (TOUT) tick();
    i_fft_data = rand_data(); i_fft_ready = 1'b1; tick(); i_fft_ready = 1'b0;
    budget = 0;
    while (to_q.size() == b_to && budget < 200) begin tick(); budget++; end
    check("timeout_cnt", to_q.size() - b_to, 1);
    if (to_q.size() > b_to && start_q.size() > b_start) begin
      check("timeout_lat", to_q[b_to] - start_q[b_start], TOUT);
      check("timeout_start_lat", start_q[b_start] - s, 1);
    end
    repeat (20) tick();
    check("timeout_busy", o_busy, 0);
    check("timeout_no_dv", tx_q.size() - b_tx, 0);
    check("timeout_no_done", done_q.size() - b_done, 0);

    // Ready on the last cycle before the timeout wins.
    run_frame(rand_data(), TOUT - 1, 3, 0, 1'b0, 1'b0);
    // Overrun: 300 triggers during a frame saturate the drop counter.
    run_frame(rand_data(), 10, 40, 300, 1'b0, 1'b0);
    // Snapshot: input bus forced to all-ones after capture.
    run_frame(rand_data(), 2, 5, 0, 1'b1, 1'b0);
    // Backpressure: ready held low in SEND.
    run_frame(rand_data(), 1, 4, 0, 1'b0, 1'b1);

    // Reset one cycle after the fifth DV.
    spi_lat = 10;
    b_tx = tx_q.size();
    i_sample = 1'b1; tick(); i_sample = 1'b0;
    repeat (5) tick();
    i_fft_data = rand_data(); i_fft_ready = 1'b1; tick(); i_fft_ready = 1'b0;
    budget = 0;
    while (tx_q.size() < b_tx + 5 && budget < 2000) begin tick(); budget++; end
    check("pre_reset_dv", tx_q.size() - b_tx, 5);
    i_Rst_L = 1'b0; tick(); i_Rst_L = 1'b1;
    drop_exp = 0;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_dv", o_tx_dv, 0);
    check("mid_rst_byte", o_tx_byte, 0);
    check("mid_rst_drop", o_drop_cnt, 0);
    check("mid_rst_done", o_frame_done, 0);
    check("mid_rst_timeout", o_timeout, 0);
    repeat (100) tick();
    check("post_rst_no_dv", tx_q.size() - b_tx, 5);
    check("post_rst_busy", o_busy, 0);

    for (int f = 0; f < 3; f++)
      run_frame(rand_data(), $urandom_range(0, TOUT - 1), $urandom_range(1, 20),
                $urandom_range(0, 5), 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
